// File: rtl/rotsq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rotsq_pkg
//  Description : Shared constants, types and the position-to-digit mapping
//                for the rotating-square multi-digit display driver.
//                Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
package rotsq_pkg;

  localparam logic [7:0] SSEG_UPPER = 8'h9C;  // square in the top half of a digit
  localparam logic [7:0] SSEG_LOWER = 8'hA3;  // square in the bottom half of a digit
  localparam logic [7:0] SSEG_BLANK = 8'hFF;  // all segments off

  // Digit index (0 = rightmost) and the glyph lit on that digit.
  typedef struct packed {
    logic [2:0] digit;
    logic [7:0] glyph;
  } glyph_loc_t;

  // The first DIGITS positions walk the upper square from the leftmost digit
  // to the rightmost; the remaining positions bring the lower square back
  // from the rightmost digit to the leftmost.
  function automatic glyph_loc_t glyph_at(input logic [3:0] pos, input int digits);
    glyph_loc_t loc;
    if (int'(pos) < digits) begin
      loc.digit = 3'(digits - 1 - int'(pos));
      loc.glyph = SSEG_UPPER;
    end else begin
      loc.digit = 3'(int'(pos) - digits);
      loc.glyph = SSEG_LOWER;
    end
    return loc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotating_square_multi_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : W-bit prescaler. Counts while en=1 and holds while en=0.
//                tick is high for the single enabled cycle in which the
//                count sits at 2^W-1; the count wraps to 0 on that edge.
//  Ports       : clk   - system clock
//                reset - synchronous, active-high
//                en    - count enable
//                tick  - one-cycle wrap strobe (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [W-1:0] count;

  // Gated by en so that dropping en on the wrap cycle suppresses the tick.
  assign tick = en && (&count);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rotating_square_multi.sv
`default_nettype none
// ============================================================================
//  Module      : rotating_square_multi
//  Description : Drives a time-multiplexed bank of DIGITS active-low
//                seven-segment digits with a square glyph that walks around
//                the bank (loop mode, either direction) or ping-pongs along
//                the top row (bounce mode).
//  Ports       : clk    - system clock
//                reset  - synchronous, active-high
//                en     - 1 lets the rotation advance, 0 freezes it
//                cw     - loop direction: 1 increments pos, 0 decrements
//                bounce - 1 selects top-row ping-pong mode
//                an     - digit enables, active-low, an[0] = rightmost
//                sseg   - segments, active-low, {dp,g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module rotating_square_multi
  import rotsq_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int N      = 27,
  parameter int R      = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cw,
  input  logic              bounce,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        sseg
);

  localparam logic [3:0] POS_LAST   = 4'(2 * DIGITS - 1);
  localparam logic [3:0] POS_LOWER  = 4'(DIGITS);
  localparam logic [3:0] TOP_LAST   = 4'(DIGITS - 1);
  localparam logic [3:0] TOP_PENULT = 4'(DIGITS - 2);
  localparam logic [2:0] SCAN_LAST  = 3'(DIGITS - 1);

  logic              rot_tick;
  logic              scan_tick;
  logic [2:0]        scan;
  logic [3:0]        pos;
  logic [3:0]        pos_next;
  logic              dir;
  logic              dir_next;
  logic [DIGITS-1:0] an_next;
  logic [7:0]        sseg_next;
  glyph_loc_t        loc;

  tick_gen #(.W(N)) u_rot_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (rot_tick)
  );

  tick_gen #(.W(R)) u_scan_tick (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .tick  (scan_tick)
  );

  // Next position, applied only on rot_tick. Bounce mode first pulls a
  // lower-row position back to the start of the top row, then reflects at
  // either end of the top row.
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    if (bounce) begin
      if (pos >= POS_LOWER) begin
        pos_next = 4'd0;
        dir_next = 1'b1;
      end else if (dir && (pos == TOP_LAST)) begin
        pos_next = TOP_PENULT;
        dir_next = 1'b0;
      end else if (!dir && (pos == 4'd0)) begin
        pos_next = 4'd1;
        dir_next = 1'b1;
      end else if (dir) begin
        pos_next = pos + 4'd1;
      end else begin
        pos_next = pos - 4'd1;
      end
    end else if (cw) begin
      pos_next = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
    end else begin
      pos_next = (pos == 4'd0) ? POS_LAST : pos - 4'd1;
    end
  end

  assign loc       = glyph_at(pos, DIGITS);
  assign sseg_next = (scan == loc.digit) ? loc.glyph : SSEG_BLANK;

  for (genvar i = 0; i < DIGITS; i++) begin : g_an
    assign an_next[i] = (scan != 3'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan <= 3'd0;
      pos  <= 4'd0;
      dir  <= 1'b1;
      an   <= '1;
      sseg <= SSEG_BLANK;
    end else begin
      if (scan_tick) begin
        scan <= (scan == SCAN_LAST) ? 3'd0 : scan + 3'd1;
      end
      if (rot_tick) begin
        pos <= pos_next;
        dir <= dir_next;
      end
      // Outputs are decoded from the pre-edge scan/pos, hence one clock of lag.
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/rotating_square_multi.md
# rotating_square_multi

Parametrised successor to the rotating-square display driver. It drives a time-multiplexed bank of `DIGITS` active-low seven-segment digits. A single "square" glyph walks around the bank: upper square across the top row, lower square back along the bottom row. The block supports enable, direction, and a new bounce mode that sweeps the top row back and forth. It sits between the board switch inputs and the `an`/`sseg` display pins.

## Interface
- `DIGITS`, 8, number of digits; legal range 2..8.
- `N`, 27, rotation prescaler width; one step every 2^N enabled cycles.
- `R`, 18, refresh prescaler width; scan advances every 2^R cycles.
- `clk` in 1 — single system clock.
- `reset` in 1 — one clock; reset is synchronous and active-high.
- `en` in 1 — 1 lets the rotation prescaler count; 0 freezes rotation.
- `cw` in 1 — loop-mode direction: 1 increments position, 0 decrements.
- `bounce` in 1 — 1 selects top-row ping-pong mode; `cw` is ignored.
- `an` out `DIGITS` — digit enables, active-low, one-hot-zero.
- `sseg` out 8 — segments, active-low, {dp,g,f,e,d,c,b,a}.

## Operation
- **Rotation tick:** N-bit counter increments only when `en`=1. `rot_tick` asserts for one cycle when the counter is at 2^N−1 and `en`=1; the counter then wraps to 0. While `en`=0 the counter holds its value.
- **Refresh tick:** R-bit free-running counter, independent of `en`. It produces `scan_tick` at wrap. `scan` (3 bits) advances 0..DIGITS−1 and then wraps to 0.
- **Position `pos`:** range 0..2·DIGITS−1.
  - pos < DIGITS: upper square (8'h9C) on digit DIGITS−1−pos, moving left to right.
  - pos ≥ DIGITS: lower square (8'hA3) on digit pos−DIGITS, moving right to left.
  - Digit 0 is `an[0]`, the rightmost digit.
- **Loop mode (`bounce`=0), on `rot_tick`:**
  - `cw`=1: pos ← (pos+1) mod 2·DIGITS.
  - `cw`=0: pos ← (pos−1) mod 2·DIGITS.
- **Bounce mode (`bounce`=1), on `rot_tick`, using internal `dir` (1 = forward):**
  - If pos ≥ DIGITS: pos ← 0, dir ← 1.
  - Else if dir=1 and pos=DIGITS−1: pos ← DIGITS−2, dir ← 0.
  - Else if dir=0 and pos=0: pos ← 1, dir ← 1.
  - Otherwise: pos ← pos ± 1 according to `dir`.
  - Loop mode leaves `dir` unchanged.
- **Output mapping (registered):**
  - `an` ← all ones with bit `scan` cleared.
  - `sseg` ← glyph if `scan` equals the active digit, else 8'hFF.
- **Reset values:** `an`=all ones, `sseg`=8'hFF, pos=0, dir=1, scan=0, both counters 0.

## Timing
- `an`/`sseg` lag `scan`/`pos` by exactly one clock.
- First `rot_tick` occurs 2^N enabled cycles after reset release. First `scan_tick` occurs 2^R cycles after reset release.
- First output edge after reset release: `an` has bit 0 low. `sseg`=8'hFF, because the active digit at pos 0 is DIGITS−1.
- `cw`, `bounce`, `en` are sampled on the `rot_tick` cycle; values in that cycle decide the step.
- `en` falling on the tick cycle suppresses that tick.
- `scan_tick` and `rot_tick` in the same cycle both take effect. The output reflects both updates one cycle later.
- `reset` asserted at any point: all state and outputs take reset values at the next edge, overriding any tick.

## Structure
- Package `rotsq_pkg`:
  - constants `SSEG_UPPER`=8'h9C, `SSEG_LOWER`=8'hA3, `SSEG_BLANK`=8'hFF.
  - function mapping (pos, DIGITS) to {digit index, glyph}.
- Sub-module `tick_gen #(W)`: counter with `en` input and one-cycle `tick` output, wrap at 2^W−1. Instantiated twice: rotation with `en`, refresh with `en` tied to 1.
- Top holds the `pos`/`dir` logic, `scan` counter, and output registers.

## Test plan
All scenarios use DIGITS=4, N=2, R=2.
1. Reset held 3 cycles → `an`=4'hF, `sseg`=8'hFF. First cycle after release → `an`=4'b1110, `sseg`=8'hFF.
2. `en`=1, `cw`=1 → pos steps 0,1,…,7,0 every 4 cycles. With pos=0, scan=3 → `an`=4'b0111, `sseg`=8'h9C. With pos=4, scan=0 → `an`=4'b1110, `sseg`=8'hA3.
3. `en`=1, `cw`=0 from reset → pos 0,7,6,5. With pos=7, scan=3 → `sseg`=8'hA3.
4. `en` dropped at pos=3 for 20 cycles → pos stays 3, scan keeps cycling. Re-enable → pos=4 exactly 4 enabled cycles later.
5. `bounce`=1 from pos=5 → next tick pos=0, then 1,2,3,2,1,0,1. `sseg` is never 8'hA3.
6. `reset` asserted at pos=5 on a `rot_tick` cycle → next edge pos=0, dir=1, `an`=4'hF, `sseg`=8'hFF.
